debounce_bank: RTL and testbench



---
 rtl/debounce_pkg.sv | 25 ++
 rtl/debounce_channel.sv | 110 +++++++++++
 rtl/debounce_bank.sv | 79 +++++++
 tb/tb_debounce_bank.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/debounce_pkg.sv
// ----------------------------------------------------------------------------
// debounce_pkg
//
// Shared defaults and helpers for the debounce_bank multi-channel debouncer.
//
// Contents:
//   DEF_TICK_DIV        default clk cycles per debounce tick (1 ms at 50 MHz)
//   DEF_DEBOUNCE_TICKS  default ticks of stable input needed to accept a level
//   DEF_LONG_TICKS      default ticks held high before a long-press event
//   DEF_SYNC_STAGES     default synchroniser depth
//   cnt_width(n)        width of a counter that must hold the value n
// ----------------------------------------------------------------------------
package debounce_pkg;

    localparam int DEF_TICK_DIV       = 50000;
    localparam int DEF_DEBOUNCE_TICKS = 20;
    localparam int DEF_LONG_TICKS     = 1000;
    localparam int DEF_SYNC_STAGES    = 2;

    // Bits needed for a counter that runs 0..n inclusive.
    function automatic int cnt_width(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/debounce_channel.sv
// ----------------------------------------------------------------------------
// debounce_channel
//
// One debounced input: synchroniser, candidate/stability counter, accepted
// level, rise/fall event pulses and, when DEBOUNCE_LONGPRESS_EN is defined,
// a hold counter that emits a single long_press pulse per press.
//
// Ports:
//   clk         system clock
//   reset       synchronous, active-high reset
//   tick        shared debounce tick from the prescaler in the top
//   raw         asynchronous pin input
//   debounced   filtered level
//   rise        one-cycle pulse when debounced goes 0->1
//   fall        one-cycle pulse when debounced goes 1->0
//   long_press  one-cycle pulse after LONG_TICKS ticks held high
//               (constant 0 unless DEBOUNCE_LONGPRESS_EN is defined)
// ----------------------------------------------------------------------------
module debounce_channel
    import debounce_pkg::*;
#(
    parameter int   SYNC_STAGES    = DEF_SYNC_STAGES,
    parameter int   DEBOUNCE_TICKS = DEF_DEBOUNCE_TICKS,
    parameter int   LONG_TICKS     = DEF_LONG_TICKS,
    parameter logic RESET_LEVEL    = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic tick,
    input  logic raw,
    output logic debounced,
    output logic rise,
    output logic fall,
    output logic long_press
);

    localparam int             CW      = cnt_width(DEBOUNCE_TICKS);
    localparam logic [CW-1:0]  CNT_MAX = CW'(DEBOUNCE_TICKS);

    logic [SYNC_STAGES-1:0] sync;
    logic                   cand;
    logic [CW-1:0]          cnt;
    logic                   s;

    assign s = sync[SYNC_STAGES-1];

    // Any disagreement between the synchronised input and the candidate
    // restarts the window immediately, tick or not. The counter saturates at
    // CNT_MAX, so the accepted level can only change once per stable window.
    always_ff @(posedge clk) begin
        // NOTE: every register, including the synchroniser, is reset here so
        // no stale pin history survives a reset and no pulse comes out of it.
        if (reset) begin
            sync      <= {SYNC_STAGES{RESET_LEVEL}};
            cand      <= RESET_LEVEL;
            cnt       <= '0;
            debounced <= RESET_LEVEL;
            rise      <= 1'b0;
            fall      <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments let each stage see the previous
            // cycle's value of its neighbour, which is what makes a shift chain.
            sync <= {sync[SYNC_STAGES-2:0], raw};
            rise <= 1'b0;
            fall <= 1'b0;
            if (s != cand) begin
                cand <= s;
                cnt  <= '0;
            end else if (cnt < CNT_MAX) begin
                if (tick) begin
                    cnt <= cnt + CW'(1);
                end
            end else if (debounced != cand) begin
                debounced <= cand;
                rise      <= cand;
                fall      <= ~cand;
            end
        end
    end

`ifdef DEBOUNCE_LONGPRESS_EN
    localparam int             HW       = cnt_width(LONG_TICKS);
    localparam logic [HW-1:0]  HOLD_MAX = HW'(LONG_TICKS);

    logic [HW-1:0] hold;

    // Counts ticks while the accepted level is high; the pulse fires on the
    // single edge where the counter reaches HOLD_MAX, and saturation keeps it
    // from firing again until a release clears the counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            hold       <= '0;
            long_press <= 1'b0;
        end else begin
            long_press <= 1'b0;
            if (!debounced) begin
                hold <= '0;
            end else if (tick && (hold < HOLD_MAX)) begin
                hold       <= hold + HW'(1);
                long_press <= (hold == HOLD_MAX - HW'(1));
            end
        end
    end
`else
    // Without the long-press feature LONG_TICKS has no effect; the term below
    // is constant false and only keeps the parameter referenced.
    assign long_press = 1'b0 & (LONG_TICKS < 0);
`endif

endmodule

// File: rtl/debounce_bank.sv
// ----------------------------------------------------------------------------
// debounce_bank
//
// CHANNELS independent debouncers sharing one tick prescaler, so that long
// debounce windows only need narrow per-channel counters. Optional long-press
// detection is enabled by defining the macro DEBOUNCE_LONGPRESS_EN.
//
// Ports:
//   clk         system clock
//   reset       synchronous, active-high reset
//   raw         [CHANNELS-1:0] asynchronous pin inputs
//   debounced   [CHANNELS-1:0] filtered levels
//   rise        [CHANNELS-1:0] one-cycle pulse on debounced 0->1
//   fall        [CHANNELS-1:0] one-cycle pulse on debounced 1->0
//   long_press  [CHANNELS-1:0] one-cycle pulse after LONG_TICKS ticks high
// ----------------------------------------------------------------------------
module debounce_bank
    import debounce_pkg::*;
#(
    parameter int   CHANNELS       = 4,
    parameter int   SYNC_STAGES    = DEF_SYNC_STAGES,
    parameter int   TICK_DIV       = DEF_TICK_DIV,
    parameter int   DEBOUNCE_TICKS = DEF_DEBOUNCE_TICKS,
    parameter int   LONG_TICKS     = DEF_LONG_TICKS,
    parameter logic RESET_LEVEL    = 1'b0
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [CHANNELS-1:0] raw,
    output logic [CHANNELS-1:0] debounced,
    output logic [CHANNELS-1:0] rise,
    output logic [CHANNELS-1:0] fall,
    output logic [CHANNELS-1:0] long_press
);

    logic tick;

    // Prescaler: tick is high during the cycle the counter sits at
    // TICK_DIV-1. A divide of one needs no counter at all.
    if (TICK_DIV == 1) begin : g_no_div
        assign tick = 1'b1;
    end else begin : g_div
        localparam int            PW       = $clog2(TICK_DIV);
        localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);

        logic [PW-1:0] pre;

        always_ff @(posedge clk) begin
            if (reset) begin
                pre <= '0;
            end else if (pre == PRE_LAST) begin
                pre <= '0;
            end else begin
                pre <= pre + PW'(1);
            end
        end

        assign tick = (pre == PRE_LAST);
    end

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        debounce_channel #(
            .SYNC_STAGES    (SYNC_STAGES),
            .DEBOUNCE_TICKS (DEBOUNCE_TICKS),
            .LONG_TICKS     (LONG_TICKS),
            .RESET_LEVEL    (RESET_LEVEL)
        ) u_ch (
            .clk        (clk),
            .reset      (reset),
            .tick       (tick),
            .raw        (raw[i]),
            .debounced  (debounced[i]),
            .rise       (rise[i]),
            .fall       (fall[i]),
            .long_press (long_press[i])
        );
    end

endmodule

// File: tb/tb_debounce_bank.sv
// ----------------------------------------------------------------------------
// tb_debounce_bank
//
// Directed bench for debounce_bank. Three instances share clock and reset:
//   u_a  TICK_DIV=1,  DEBOUNCE_TICKS=4, LONG_TICKS=16, RESET_LEVEL=0
//   u_b  same as u_a but RESET_LEVEL=1
//   u_c  TICK_DIV=10, DEBOUNCE_TICKS=3
// Inputs change and outputs are sampled on the falling clock edge. Long-press
// expectations follow the DEBOUNCE_LONGPRESS_EN macro.
// ----------------------------------------------------------------------------
module tb_debounce_bank;

    logic clk = 1'b0;
    logic reset;
    logic [3:0] raw_a, raw_b, raw_c;
    logic [3:0] deb_a, rise_a, fall_a, lp_a;
    logic [3:0] deb_b, rise_b, fall_b, lp_b;
    logic [3:0] deb_c, rise_c, fall_c, lp_c;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    debounce_bank #(
        .CHANNELS(4), .SYNC_STAGES(2), .TICK_DIV(1), .DEBOUNCE_TICKS(4),
        .LONG_TICKS(16), .RESET_LEVEL(1'b0)
    ) u_a (
        .clk(clk), .reset(reset), .raw(raw_a), .debounced(deb_a),
        .rise(rise_a), .fall(fall_a), .long_press(lp_a)
    );

    debounce_bank #(
        .CHANNELS(4), .SYNC_STAGES(2), .TICK_DIV(1), .DEBOUNCE_TICKS(4),
        .LONG_TICKS(16), .RESET_LEVEL(1'b1)
    ) u_b (
        .clk(clk), .reset(reset), .raw(raw_b), .debounced(deb_b),
        .rise(rise_b), .fall(fall_b), .long_press(lp_b)
    );

    debounce_bank #(
        .CHANNELS(4), .SYNC_STAGES(2), .TICK_DIV(10), .DEBOUNCE_TICKS(3),
        .LONG_TICKS(16), .RESET_LEVEL(1'b0)
    ) u_c (
        .clk(clk), .reset(reset), .raw(raw_c), .debounced(deb_c),
        .rise(rise_c), .fall(fall_c), .long_press(lp_c)
    );

    typedef struct {
        logic [3:0] raw;
        logic [3:0] deb;
        logic [3:0] rise;
        logic [3:0] fall;
    } vec_t;

    vec_t vec [20];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic fill(input int lo, input int hi, input logic [3:0] raw,
                        input logic [3:0] deb, input logic [3:0] rise, input logic [3:0] fall);
        for (int i = lo; i <= hi; i++) begin
            vec[i].raw  = raw;
            vec[i].deb  = deb;
            vec[i].rise = rise;
            vec[i].fall = fall;
        end
    endtask

    // Holds reset for n rising edges and releases it on the following
    // falling edge; the last reset edge is "edge 0" for the caller.
    task automatic apply_reset(input int n);
        reset = 1'b1;
        repeat (n) @(negedge clk);
        reset = 1'b0;
    endtask

    function automatic logic [3:0] lp_expect(input bit fire);
`ifdef DEBOUNCE_LONGPRESS_EN
        return fire ? 4'b1000 : 4'b0000;
`else
        return (fire & 1'b0) ? 4'b1000 : 4'b0000;
`endif
    endfunction

    initial begin
        raw_a = 4'h0;
        raw_b = 4'hF;
        raw_c = 4'h0;
        reset = 1'b1;
        @(negedge clk);

        // ---------------- reset state ----------------
        apply_reset(3);
        check("reset_a_deb",  deb_a,  4'h0);
        check("reset_a_rise", rise_a, 4'h0);
        check("reset_a_fall", fall_a, 4'h0);
        check("reset_a_lp",   lp_a,   4'h0);
        check("reset_b_deb",  deb_b,  4'hF);
        check("reset_b_rise", rise_b, 4'h0);
        check("reset_b_fall", fall_b, 4'h0);
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            check($sformatf("post_reset_b_deb[%0d]", k),  deb_b,  4'hF);
            check($sformatf("post_reset_b_rise[%0d]", k), rise_b, 4'h0);
            check($sformatf("post_reset_b_fall[%0d]", k), fall_b, 4'h0);
            check($sformatf("post_reset_a_deb[%0d]", k),  deb_a,  4'h0);
        end

        // ---------------- clean step, glitch, simultaneous channels ----------------
        // ch0 and ch2 step high together, ch1 glitches high for 5 cycles,
        // ch0/ch2 release at entry 10. Entry i is applied before edge i+1.
        fill(0,  4,  4'b0111, 4'b0000, 4'b0000, 4'b0000);
        fill(5,  6,  4'b0101, 4'b0000, 4'b0000, 4'b0000);
        fill(7,  7,  4'b0101, 4'b0101, 4'b0101, 4'b0000);
        fill(8,  9,  4'b0101, 4'b0101, 4'b0000, 4'b0000);
        fill(10, 16, 4'b0000, 4'b0101, 4'b0000, 4'b0000);
        fill(17, 17, 4'b0000, 4'b0000, 4'b0000, 4'b0101);
        fill(18, 19, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        for (int i = 0; i < 20; i++) begin
            raw_a = vec[i].raw;
            @(negedge clk);
            check($sformatf("vec_deb[%0d]", i),  deb_a,  vec[i].deb);
            check($sformatf("vec_rise[%0d]", i), rise_a, vec[i].rise);
            check($sformatf("vec_fall[%0d]", i), fall_a, vec[i].fall);
            check($sformatf("vec_lp[%0d]", i),   lp_a,   4'h0);
        end

        // ---------------- reset in the middle of a window ----------------
        raw_a = 4'b0100;
        repeat (4) @(negedge clk);
        check("midrst_pre_deb", deb_a, 4'h0);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("midrst_deb",  deb_a,  4'h0);
        check("midrst_rise", rise_a, 4'h0);
        // The window restarts from the reset edge: 8 more edges to accept.
        for (int k = 1; k <= 9; k++) begin
            @(negedge clk);
            check($sformatf("midrst_deb[%0d]", k),  deb_a,  (k >= 8) ? 4'b0100 : 4'b0000);
            check($sformatf("midrst_rise[%0d]", k), rise_a, (k == 8) ? 4'b0100 : 4'b0000);
        end

        // ---------------- long press on ch3 ----------------
        raw_a = 4'h0;
        @(negedge clk);
        apply_reset(2);
        raw_a = 4'b1000;
        for (int k = 1; k <= 50; k++) begin
            @(negedge clk);
            check($sformatf("lp_deb[%0d]", k),  deb_a,  (k >= 8 && k < 48) ? 4'b1000 : 4'b0000);
            check($sformatf("lp_rise[%0d]", k), rise_a, (k == 8)  ? 4'b1000 : 4'b0000);
            check($sformatf("lp_fall[%0d]", k), fall_a, (k == 48) ? 4'b1000 : 4'b0000);
            check($sformatf("lp_pulse[%0d]", k), lp_a, lp_expect(k == 24));
            if (k == 40) raw_a = 4'h0;
        end

        // ---------------- prescaled window with a bounce ----------------
        // Prescaler restarts at 0 with reset, so ticks land on edges 10, 20,
        // 30... ch0 steps cleanly and is accepted at edge 31. ch1 bounces low
        // for one cycle before edge 20, restarting its window at edge 23, and
        // is accepted after ticks 30, 40, 50 at edge 51.
        apply_reset(2);
        raw_c = 4'b0011;
        for (int k = 1; k <= 55; k++) begin
            if (k == 20) raw_c = 4'b0001;
            if (k == 21) raw_c = 4'b0011;
            @(negedge clk);
            check($sformatf("pre_deb[%0d]", k), deb_c,
                  {2'b00, (k >= 51) ? 1'b1 : 1'b0, (k >= 31) ? 1'b1 : 1'b0});
            check($sformatf("pre_rise[%0d]", k), rise_c,
                  {2'b00, (k == 51) ? 1'b1 : 1'b0, (k == 31) ? 1'b1 : 1'b0});
            check($sformatf("pre_fall[%0d]", k), fall_c, 4'h0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
